// File: rtl/ssp_pkg.sv
// ssp_pkg: definitions shared by the SSP host sequencer files.
//   state_e : sequencer FSM state encoding (3 bits)
//   WORD_W  : SSP data word width
//   cmd_t   : queued command record {write, data}, 9 bits
package ssp_pkg;

    localparam int unsigned WORD_W = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWr     = 3'd1,
        StRd     = 3'd2,
        StRdWait = 3'd3,
        StRsp    = 3'd4
    } state_e;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/ssp_host_seq_if.sv
// ssp_host_seq_if: command/response handshake plus SSP host bus signals.
//   master : sequencer view (drives CMD_READY, RSP_*, PSEL, PWRITE, PWDATA, BUSY)
//   slave  : environment view (drives CMD_*, RSP_READY, PRDATA, SSPTXINTR)
interface ssp_host_seq_if;
    import ssp_pkg::*;

    logic              CMD_VALID;
    logic              CMD_WRITE;
    logic [WORD_W-1:0] CMD_DATA;
    logic              CMD_READY;
    logic              RSP_VALID;
    logic [WORD_W-1:0] RSP_DATA;
    logic              RSP_READY;
    logic              PSEL;
    logic              PWRITE;
    logic [WORD_W-1:0] PWDATA;
    logic [WORD_W-1:0] PRDATA;
    logic              SSPTXINTR;
    logic              BUSY;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_DATA, RSP_READY, PRDATA, SSPTXINTR,
        output CMD_READY, RSP_VALID, RSP_DATA, PSEL, PWRITE, PWDATA, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_DATA, RSP_READY, PRDATA, SSPTXINTR,
        input  CMD_READY, RSP_VALID, RSP_DATA, PSEL, PWRITE, PWDATA, BUSY
    );

endinterface

// File: rtl/ssp_cmd_queue.sv
// ssp_cmd_queue: synchronous FIFO of DEPTH x cmd_t entries.
//   i_clk, i_clr    : clock, synchronous active-high clear (empties the queue)
//   i_push, i_cmd   : enqueue i_cmd (ignored when full)
//   i_pop           : drop the head entry (ignored when empty)
//   o_full, o_empty : occupancy flags
//   o_head          : oldest entry, valid when !o_empty
module ssp_cmd_queue
    import ssp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_push,
    input  cmd_t i_cmd,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output cmd_t o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t           r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == (AW + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage needs no reset; only pointers and occupancy are cleared.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_cmd;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/ssp_host_seq.sv
// ssp_host_seq: queues master commands and turns each into a single-cycle
// PSEL access on the SSP host bus; read data comes back on a valid/ready port.
//   PCLK  : clock
//   CLEAR : synchronous active-high reset
//   bus   : command/response handshake and SSP bus (ssp_host_seq_if.master)
// Optional build macro SSP_HOST_SEQ_STATS_EN adds WR_COUNT, RD_COUNT
// (wrapping access counters) and STALL_COUNT (saturating TX-full stall count).
module ssp_host_seq
    import ssp_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RD_WAIT   = 1
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    ssp_host_seq_if.master        bus
`ifdef SSP_HOST_SEQ_STATS_EN
    ,
    output logic [15:0]           WR_COUNT,
    output logic [15:0]           RD_COUNT,
    output logic [15:0]           STALL_COUNT
`endif
);

    state_e            r_state;
    logic [1:0]        r_wait_cnt;
    logic              r_psel;
    logic              r_pwrite;
    logic [WORD_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [WORD_W-1:0] r_rsp_data;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    cmd_t              w_cmd;
    cmd_t              w_head;

    assign w_cmd.write = bus.CMD_WRITE;
    assign w_cmd.data  = bus.CMD_DATA;

    // READY is held low while CLEAR is asserted so nothing is taken during reset.
    assign bus.CMD_READY = ~CLEAR & ~w_full;
    assign w_push        = bus.CMD_VALID & bus.CMD_READY;
    // The head is consumed in the cycle its access is on the bus.
    assign w_pop         = (r_state == StWr) || (r_state == StRd);

    ssp_cmd_queue #(
        .DEPTH (CMD_DEPTH)
    ) u_queue (
        .i_clk   (PCLK),
        .i_clr   (CLEAR),
        .i_push  (w_push),
        .i_cmd   (w_cmd),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_state     <= StIdle;
            r_wait_cnt  <= '0;
            r_psel      <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_psel <= 1'b0;
            if (r_rsp_valid && bus.RSP_READY) begin
                r_rsp_valid <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    // A read head blocks everything behind it while a response
                    // is outstanding, which keeps command order intact.
                    if (!w_empty) begin
                        if (w_head.write) begin
                            if (!bus.SSPTXINTR) begin
                                r_state  <= StWr;
                                r_psel   <= 1'b1;
                                r_pwrite <= 1'b1;
                                r_pwdata <= w_head.data;
                            end
                        end else if (!r_rsp_valid) begin
                            r_state  <= StRd;
                            r_psel   <= 1'b1;
                            r_pwrite <= 1'b0;
                        end
                    end
                end
                StWr: begin
                    r_state <= StIdle;
                end
                StRd: begin
                    r_state    <= StRdWait;
                    r_wait_cnt <= 2'(RD_WAIT);
                end
                StRdWait: begin
                    r_wait_cnt <= r_wait_cnt - 2'd1;
                    if (r_wait_cnt == 2'd1) begin
                        r_rsp_data  <= bus.PRDATA;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StRsp;
                    end
                end
                StRsp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.PSEL      = r_psel;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PWDATA    = r_pwdata;
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP_DATA  = r_rsp_data;
    assign bus.BUSY      = ~w_empty | (r_state != StIdle);

`ifdef SSP_HOST_SEQ_STATS_EN
    logic [15:0] r_wr_count;
    logic [15:0] r_rd_count;
    logic [15:0] r_stall_count;

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_wr_count    <= '0;
            r_rd_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_state == StWr) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (r_state == StRd) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if ((r_state == StIdle) && !w_empty && w_head.write && bus.SSPTXINTR &&
                (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign WR_COUNT    = r_wr_count;
    assign RD_COUNT    = r_rd_count;
    assign STALL_COUNT = r_stall_count;
`endif

endmodule

// File: tb/tb_ssp_host_seq.sv
// tb_ssp_host_seq: table vectors, directed corner sequences and a random phase
// checked against a transaction-level model of the sequencer.
module tb_ssp_host_seq;
    import ssp_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RDW   = 1;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    ssp_host_seq_if bus_if ();

`ifdef SSP_HOST_SEQ_STATS_EN
    logic [15:0] wr_cnt, rd_cnt, stall_cnt;
`endif

    ssp_host_seq #(
        .CMD_DEPTH (DEPTH),
        .RD_WAIT   (RDW)
    ) dut (
        .PCLK        (clk),
        .CLEAR       (clr),
        .bus         (bus_if)
`ifdef SSP_HOST_SEQ_STATS_EN
        ,
        .WR_COUNT    (wr_cnt),
        .RD_COUNT    (rd_cnt),
        .STALL_COUNT (stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) next_edge();
    endtask

    task automatic push(input bit w, input logic [7:0] d);
        int k;
        bus_if.CMD_VALID = 1'b1;
        bus_if.CMD_WRITE = w;
        bus_if.CMD_DATA  = d;
        k = 0;
        @(negedge clk);
        while (bus_if.CMD_READY !== 1'b1 && k < 30) begin
            next_edge();
            @(negedge clk);
            k++;
        end
        if (k == 30) begin
            total++;
            bad++;
            $display("FAIL push_timeout: CMD_READY got 0 required 1");
        end
        next_edge();
        bus_if.CMD_VALID = 1'b0;
    endtask

    // Bus access recorder for directed sequences
    bit         rec_on = 1'b0;
    int         ev_cyc[$];
    bit         ev_wr[$];
    logic [7:0] ev_data[$];

    always @(negedge clk) begin
        if (rec_on && bus_if.PSEL === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_wr.push_back(bus_if.PWRITE);
            ev_data.push_back(bus_if.PWDATA);
        end
    end

    task automatic clear_ev();
        ev_cyc.delete();
        ev_wr.delete();
        ev_data.delete();
    endtask

    // Transaction-level model for the random phase
    typedef struct {
        bit         wr;
        logic [7:0] d;
    } mc_t;

    bit         rnd_on = 1'b0;
    mc_t        m_q[$];
    logic [7:0] m_rsp[$];
    int         m_cnt;
    int         m_due;
    bit         m_prev_tx;
    mc_t        mc;
    bit         m_pushed;

    always @(negedge clk) begin
        if (rnd_on) begin
            m_pushed = bus_if.CMD_VALID & bus_if.CMD_READY;
            chk("rnd_cmd_ready", bus_if.CMD_READY, m_cnt < DEPTH);
            if (m_due > 0) begin
                m_due--;
                if (m_due == 0) m_rsp.push_back(bus_if.PRDATA);
            end
            if (bus_if.PSEL) begin
                if (m_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_spurious_psel: got access, required none");
                end else begin
                    mc = m_q.pop_front();
                    m_cnt--;
                    chk("rnd_pwrite", bus_if.PWRITE, mc.wr);
                    if (mc.wr) begin
                        chk("rnd_pwdata", bus_if.PWDATA, mc.d);
                        chk("rnd_tx_gate", m_prev_tx, 0);
                    end else begin
                        m_due = RDW;
                    end
                end
            end
            if (bus_if.RSP_VALID && bus_if.RSP_READY) begin
                if (m_rsp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_spurious_rsp: got %0h, required none", bus_if.RSP_DATA);
                end else begin
                    chk("rnd_rsp_data", bus_if.RSP_DATA, m_rsp.pop_front());
                end
            end
            if (m_pushed) begin
                m_q.push_back('{bus_if.CMD_WRITE, bus_if.CMD_DATA});
                m_cnt++;
            end
            m_prev_tx = bus_if.SSPTXINTR;
        end
    end

    typedef struct {
        bit         wr;
        logic [7:0] d;
        logic [7:0] prd;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 8'h5A, 8'h00, 8'h5A};
        vt[1] = '{1'b0, 8'h00, 8'hC3, 8'hC3};
        vt[2] = '{1'b1, 8'hFF, 8'h12, 8'hFF};
        vt[3] = '{1'b0, 8'hFF, 8'h00, 8'h00};

        // 1: reset held 3 cycles with a command offered
        clr              = 1'b1;
        bus_if.CMD_VALID = 1'b1;
        bus_if.CMD_WRITE = 1'b1;
        bus_if.CMD_DATA  = 8'h55;
        bus_if.RSP_READY = 1'b0;
        bus_if.PRDATA    = 8'h00;
        bus_if.SSPTXINTR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_edge();
            @(negedge clk);
            chk("rst_cmd_ready", bus_if.CMD_READY, 0);
            chk("rst_psel", bus_if.PSEL, 0);
            chk("rst_pwrite", bus_if.PWRITE, 0);
            chk("rst_pwdata", bus_if.PWDATA, 0);
            chk("rst_rsp_valid", bus_if.RSP_VALID, 0);
            chk("rst_rsp_data", bus_if.RSP_DATA, 0);
            chk("rst_busy", bus_if.BUSY, 0);
        end
        next_edge();
        clr              = 1'b0;
        bus_if.CMD_VALID = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus_if.CMD_READY, 1);
        chk("post_rst_busy", bus_if.BUSY, 0);
        next_edge();

        // Table vectors: one command into an empty queue, exact issue latency
        for (int i = 0; i < 4; i++) begin
            bus_if.PRDATA    = vt[i].prd;
            bus_if.RSP_READY = 1'b0;
            push(vt[i].wr, vt[i].d);
            @(negedge clk);
            chk("vec_lat_early", bus_if.PSEL, 0);
            next_edge();
            @(negedge clk);
            chk("vec_psel", bus_if.PSEL, 1);
            chk("vec_pwrite", bus_if.PWRITE, vt[i].wr);
            if (vt[i].wr) begin
                chk("vec_pwdata", bus_if.PWDATA, vt[i].exp);
            end else begin
                next_edge();
                next_edge();
                @(negedge clk);
                chk("vec_rsp_valid", bus_if.RSP_VALID, 1);
                chk("vec_rsp_data", bus_if.RSP_DATA, vt[i].exp);
                next_edge();
                bus_if.RSP_READY = 1'b1;
                next_edge();
                bus_if.RSP_READY = 1'b0;
            end
            wait_cyc(3);
            @(negedge clk);
            chk("vec_idle_busy", bus_if.BUSY, 0);
            chk("vec_idle_rsp", bus_if.RSP_VALID, 0);
            next_edge();
        end

        rec_on = 1'b1;

        // 2: back-to-back writes
        clear_ev();
        push(1'b1, 8'hA5);
        push(1'b1, 8'h3C);
        wait_cyc(8);
        @(negedge clk);
        chk("t2_count", ev_cyc.size(), 2);
        chk("t2_data0", ev_data[0], 8'hA5);
        chk("t2_data1", ev_data[1], 8'h3C);
        chk("t2_wr1", ev_wr[1], 1);
        chk("t2_gap", ev_cyc[1] - ev_cyc[0], 2);
        chk("t2_busy", bus_if.BUSY, 0);
        next_edge();

        // 3: TX FIFO full holds off a write
        clear_ev();
        bus_if.SSPTXINTR = 1'b1;
        push(1'b1, 8'h11);
        wait_cyc(10);
        @(negedge clk);
        chk("t3_stalled", ev_cyc.size(), 0);
        chk("t3_busy", bus_if.BUSY, 1);
        next_edge();
        bus_if.SSPTXINTR = 1'b0;
        begin
            int t0;
            t0 = cyc;
            wait_cyc(3);
            @(negedge clk);
            chk("t3_count", ev_cyc.size(), 1);
            chk("t3_data", ev_data[0], 8'h11);
            chk("t3_latency_ok", (ev_cyc[0] - t0) <= 2, 1);
        end
        next_edge();

        // 4: held response blocks the next read
        clear_ev();
        bus_if.RSP_READY = 1'b0;
        bus_if.PRDATA    = 8'h5E;
        push(1'b0, 8'h00);
        wait_cyc(5);
        @(negedge clk);
        chk("t4_rsp_valid", bus_if.RSP_VALID, 1);
        chk("t4_rsp_data", bus_if.RSP_DATA, 8'h5E);
        chk("t4_rd_dir", ev_wr[0], 0);
        next_edge();
        bus_if.PRDATA = 8'h22;
        push(1'b0, 8'h00);
        wait_cyc(5);
        @(negedge clk);
        chk("t4_blocked", ev_cyc.size(), 1);
        chk("t4_held_valid", bus_if.RSP_VALID, 1);
        chk("t4_held_data", bus_if.RSP_DATA, 8'h5E);
        next_edge();
        bus_if.RSP_READY = 1'b1;
        next_edge();
        bus_if.RSP_READY = 1'b0;
        wait_cyc(6);
        @(negedge clk);
        chk("t4_second_rd", ev_cyc.size(), 2);
        chk("t4_rsp2_valid", bus_if.RSP_VALID, 1);
        chk("t4_rsp2_data", bus_if.RSP_DATA, 8'h22);
        next_edge();
        bus_if.RSP_READY = 1'b1;
        next_edge();
        bus_if.RSP_READY = 1'b0;
        @(negedge clk);
        chk("t4_rsp_clear", bus_if.RSP_VALID, 0);
        chk("t4_busy", bus_if.BUSY, 0);
        next_edge();

        // 5: queue fills, fifth command waits, order preserved
        clear_ev();
        bus_if.SSPTXINTR = 1'b1;
        for (int i = 1; i <= 4; i++) push(1'b1, 8'(i));
        @(negedge clk);
        chk("t5_full_ready", bus_if.CMD_READY, 0);
        chk("t5_no_issue", ev_cyc.size(), 0);
        next_edge();
        bus_if.SSPTXINTR = 1'b0;
        push(1'b1, 8'h05);
        wait_cyc(14);
        @(negedge clk);
        chk("t5_count", ev_cyc.size(), 5);
        for (int i = 0; i < 5; i++) chk("t5_order", ev_data[i], 32'(i + 1));
        chk("t5_busy", bus_if.BUSY, 0);
        next_edge();

        // 6: reset during the read wait
        bus_if.RSP_READY = 1'b0;
        bus_if.PRDATA    = 8'h99;
        push(1'b0, 8'h00);
        push(1'b1, 8'h44);
        next_edge();
        clr = 1'b1;
        next_edge();
        clr = 1'b0;
        clear_ev();
        @(negedge clk);
        chk("t6_psel_drop", bus_if.PSEL, 0);
        chk("t6_rsp_valid", bus_if.RSP_VALID, 0);
        chk("t6_busy", bus_if.BUSY, 0);
        wait_cyc(5);
        @(negedge clk);
        chk("t6_no_issue", ev_cyc.size(), 0);
        chk("t6_rsp_still0", bus_if.RSP_VALID, 0);
        next_edge();
        bus_if.PRDATA = 8'h77;
        push(1'b0, 8'h00);
        wait_cyc(6);
        @(negedge clk);
        chk("t6_fresh_valid", bus_if.RSP_VALID, 1);
        chk("t6_fresh_data", bus_if.RSP_DATA, 8'h77);
        next_edge();
        bus_if.RSP_READY = 1'b1;
        next_edge();
        bus_if.RSP_READY = 1'b0;
        wait_cyc(2);
        rec_on = 1'b0;

        // Random phase against the transaction model
        m_q.delete();
        m_rsp.delete();
        m_cnt     = 0;
        m_due     = 0;
        m_prev_tx = 1'b0;
        rnd_on    = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bus_if.CMD_VALID = ($urandom % 3) != 0;
            bus_if.CMD_WRITE = $urandom % 2;
            bus_if.CMD_DATA  = 8'($urandom);
            bus_if.SSPTXINTR = ($urandom % 4) == 0;
            bus_if.RSP_READY = $urandom % 2;
            bus_if.PRDATA    = 8'($urandom);
            next_edge();
        end
        bus_if.CMD_VALID = 1'b0;
        bus_if.SSPTXINTR = 1'b0;
        bus_if.RSP_READY = 1'b1;
        wait_cyc(40);
        rnd_on = 1'b0;
        @(negedge clk);
        chk("rnd_drain_cmds", m_q.size(), 0);
        chk("rnd_drain_rsps", m_rsp.size(), 0);
        chk("rnd_end_busy", bus_if.BUSY, 0);
        chk("rnd_end_rsp", bus_if.RSP_VALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
